ahb_uart_tx: RTL and testbench

AHB_UART_TX -- requirements
Module: ahb_uart_tx

---
 rtl/ahb_uart_tx_if.sv | 21 ++
 rtl/ahb_uart_tx.sv | 217 +++++++++++++++++++++
 tb/tb_ahb_uart_tx.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_uart_tx_if.sv
// AHB-Lite slave-side signal bundle for the UART transmitter.
interface ahb_uart_tx_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
        output HRDATA, HREADYOUT
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
        input  HRDATA, HREADYOUT
    );
endinterface

// File: rtl/ahb_uart_tx.sv
// AHB-Lite zero-wait-state UART transmitter: DATA/STATUS/DIV registers,
// a small TX FIFO and an 8N1 serializer with a programmable bit period.
module ahb_uart_tx #(
    parameter logic [15:0] DIV_RESET  = 16'd103,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    ahb_uart_tx_if.slave ahb,
    output logic         txd
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DIV    = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------- bus data phase ----------------
    logic       acc;
    logic       dp_valid;
    logic       dp_write;
    logic [1:0] dp_addr;

    assign acc = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= 2'd0;
        end else begin
            dp_valid <= acc;
            dp_write <= acc & ahb.HWRITE;
            dp_addr  <= acc ? ahb.HADDR[3:2] : 2'd0;
        end
    end

    logic wr_en;
    logic push_req;
    assign wr_en    = dp_valid & dp_write;
    assign push_req = wr_en & (dp_addr == A_DATA);

    // ---------------- registers ----------------
    logic [15:0] div;
    logic        ovf;
    logic        pop;
    logic        push;
    logic        full;
    logic        empty;

    // A full FIFO still accepts a push when the serializer pops in the same cycle.
    assign push = push_req & (~full | pop);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            div <= DIV_RESET;
            ovf <= 1'b0;
        end else begin
            if (wr_en && dp_addr == A_DIV)
                div <= ahb.HWDATA[15:0];
            if (push_req && full && !pop)
                ovf <= 1'b1;
            else if (wr_en && dp_addr == A_STATUS && ahb.HWDATA[6])
                ovf <= 1'b0;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    head;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge HCLK) begin
        if (push)
            mem[wr_ptr] <= ahb.HWDATA[7:0];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- serializer ----------------
    state_t      state, state_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [15:0] baud, baud_nxt;
    logic        txd_nxt;
    logic        bit_end;

    assign bit_end = (baud == 16'd0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= S_IDLE;
            shreg   <= 8'd0;
            bit_idx <= 3'd0;
            baud    <= 16'd0;
            txd     <= 1'b1;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_idx <= bit_nxt;
            baud    <= baud_nxt;
            txd     <= txd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        bit_nxt   = bit_idx;
        baud_nxt  = baud;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shreg_nxt = head;
                    baud_nxt  = div;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_nxt  = div;
                    bit_nxt   = 3'd0;
                    state_nxt = S_DATA;
                end else begin
                    baud_nxt = baud - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_nxt  = div;
                    shreg_nxt = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7)
                        state_nxt = S_STOP;
                    else
                        bit_nxt = bit_idx + 3'd1;
                end else begin
                    baud_nxt = baud - 16'd1;
                end
            end
            default: begin
                // Stop bit end chains straight into the next start bit when data waits.
                if (bit_end) begin
                    baud_nxt = div;
                    if (!empty) begin
                        pop       = 1'b1;
                        shreg_nxt = head;
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    baud_nxt = baud - 16'd1;
                end
            end
        endcase

        // txd is registered from the next state so it is glitch-free and aligned with state.
        case (state_nxt)
            S_START: txd_nxt = 1'b0;
            S_DATA:  txd_nxt = shreg_nxt[0];
            default: txd_nxt = 1'b1;
        endcase
    end

    // ---------------- read mux ----------------
    logic [2:0]  cnt3;
    logic        busy;
    logic [31:0] status;

    assign cnt3   = 3'(count);
    assign busy   = (state != S_IDLE);
    assign status = {25'd0, ovf, cnt3, empty, full, busy};

    always_comb begin
        ahb.HRDATA = 32'd0;
        if (dp_valid && !dp_write) begin
            case (dp_addr)
                A_STATUS: ahb.HRDATA = status;
                A_DIV:    ahb.HRDATA = {16'd0, div};
                default:  ahb.HRDATA = 32'd0;
            endcase
        end
    end

    assign ahb.HREADYOUT = 1'b1;

    logic unused_bits;
    assign unused_bits = ^{ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HTRANS[0], ahb.HWDATA[31:16]};
endmodule

// File: tb/tb_ahb_uart_tx.sv
// Bench for ahb_uart_tx: register table, hand-built timing sequences and a
// random byte stream checked by a serial-line decoder.
module tb_ahb_uart_tx;
    logic HCLK = 1'b0;
    logic HRESETn;
    logic txd;

    ahb_uart_tx_if bus();

    ahb_uart_tx #(.DIV_RESET(16'd103), .FIFO_DEPTH(4)) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .ahb    (bus),
        .txd    (txd)
    );

    always #5 HCLK = ~HCLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- serial line decoder ----------------
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    bit         mon_en  = 1'b0;
    int         mon_div = 0;

    initial begin
        int         p;
        int         glitch;
        logic [7:0] b;
        logic       lvl;
        logic       first;
        logic       stop_lvl;
        forever begin
            @(posedge HCLK); #2;
            if (mon_en && HRESETn === 1'b1 && txd === 1'b0) begin
                p = mon_div + 1;
                glitch = 0;
                b = 8'd0;
                first = 1'b0;
                stop_lvl = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    for (int c = 0; c < p; c++) begin
                        if (k != 0 || c != 0) begin
                            @(posedge HCLK); #2;
                        end
                        lvl = txd;
                        if (c == 0) first = lvl;
                        else if (lvl !== first) glitch++;
                    end
                    if (k >= 1 && k <= 8) b[k-1] = first;
                    if (k == 9) stop_lvl = first;
                end
                check("frame_bit_timing", 32'(glitch), 32'd0);
                check("frame_stop_bit", {31'd0, stop_lvl}, 32'd1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- bus helpers ----------------
    task automatic xfer(input logic sel, input logic [1:0] trans, input logic rdy, input logic wr,
                        input logic [3:0] addr, input logic [31:0] wdata, output logic [31:0] rdata);
        bus.HSEL   = sel;
        bus.HTRANS = trans;
        bus.HREADY = rdy;
        bus.HWRITE = wr;
        bus.HADDR  = {28'h0, addr};
        @(posedge HCLK); #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HREADY = 1'b1;
        bus.HWRITE = 1'b0;
        bus.HWDATA = wdata;
        rdata      = bus.HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        logic [31:0] d;
        xfer(1'b1, 2'b10, 1'b1, 1'b1, addr, data, d);
    endtask

    task automatic rd(input logic [3:0] addr, output logic [31:0] data);
        xfer(1'b1, 2'b10, 1'b1, 1'b0, addr, 32'd0, data);
    endtask

    task automatic wait_idle(input string name, input int limit);
        logic [31:0] s;
        s = 32'hx;
        for (int n = 0; n < limit; n++) begin
            rd(4'h4, s);
            if (s === 32'h4) break;
        end
        check(name, s, 32'h4);
    endtask

    task automatic wait_not_full();
        logic [31:0] s;
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            rd(4'h4, s);
            if (s[1] === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("fifo_drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic compare_rx(input string name);
        check({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check({name, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        rx_q.delete();
        exp_q.delete();
    endtask

    // Pipelined DATA writes with no idle cycles; tx_at[i] is txd at the start of step i.
    logic [7:0] bb[8];
    logic       tx_at[10];

    task automatic burst(input int n);
        for (int i = 0; i <= n + 1; i++) begin
            tx_at[i] = txd;
            if (i < n) begin
                bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 32'h0;
            end else begin
                bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
            end
            if (i > 0 && i <= n) bus.HWDATA = {24'h0, bb[i-1]};
            @(posedge HCLK); #1;
        end
    endtask

    // ---------------- register table ----------------
    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        rdy;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[22];

    initial begin
        logic [31:0] r;
        logic        found;
        int          mism;
        logic        expb;
        logic        trace[40];
        int          highs;
        int          d;
        int          n;
        logic [7:0]  b;

        vt[0]  = '{1'b1, 2'b10, 1'b1, 1'b0, 4'h4, 32'h0,        1'b1, 32'h4};
        vt[1]  = '{1'b1, 2'b10, 1'b1, 1'b0, 4'h8, 32'h0,        1'b1, 32'd103};
        vt[2]  = '{1'b1, 2'b10, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'h0};
        vt[3]  = '{1'b1, 2'b10, 1'b1, 1'b0, 4'hC, 32'h0,        1'b1, 32'h0};
        vt[4]  = '{1'b1, 2'b10, 1'b1, 1'b1, 4'h8, 32'h1234,     1'b0, 32'h0};
        vt[5]  = '{1'b1, 2'b10, 1'b1, 1'b0, 4'h8, 32'h0,        1'b1, 32'h1234};
        vt[6]  = '{1'b1, 2'b11, 1'b1, 1'b1, 4'h8, 32'hFFFF0009, 1'b0, 32'h0};
        vt[7]  = '{1'b1, 2'b10, 1'b1, 1'b0, 4'h8, 32'h0,        1'b1, 32'h9};
        vt[8]  = '{1'b1, 2'b10, 1'b1, 1'b1, 4'hC, 32'hFFFFFFFF, 1'b0, 32'h0};
        vt[9]  = '{1'b1, 2'b10, 1'b1, 1'b0, 4'hC, 32'h0,        1'b1, 32'h0};
        vt[10] = '{1'b0, 2'b10, 1'b1, 1'b1, 4'h8, 32'h55,       1'b0, 32'h0};
        vt[11] = '{1'b1, 2'b00, 1'b1, 1'b1, 4'h8, 32'h66,       1'b0, 32'h0};
        vt[12] = '{1'b1, 2'b10, 1'b0, 1'b1, 4'h8, 32'h77,       1'b0, 32'h0};
        vt[13] = '{1'b1, 2'b10, 1'b1, 1'b0, 4'h8, 32'h0,        1'b1, 32'h9};
        vt[14] = '{1'b1, 2'b01, 1'b1, 1'b1, 4'h0, 32'hAB,       1'b0, 32'h0};
        vt[15] = '{1'b1, 2'b10, 1'b1, 1'b0, 4'h4, 32'h0,        1'b1, 32'h4};
        vt[16] = '{1'b0, 2'b10, 1'b1, 1'b0, 4'h4, 32'h0,        1'b0, 32'h0};
        vt[17] = '{1'b1, 2'b00, 1'b1, 1'b0, 4'hC, 32'h0,        1'b0, 32'h0};
        vt[18] = '{1'b1, 2'b10, 1'b1, 1'b1, 4'h4, 32'hFF,       1'b0, 32'h0};
        vt[19] = '{1'b1, 2'b10, 1'b1, 1'b0, 4'h4, 32'h0,        1'b1, 32'h4};
        vt[20] = '{1'b1, 2'b10, 1'b1, 1'b1, 4'h8, 32'd103,      1'b0, 32'h0};
        vt[21] = '{1'b1, 2'b10, 1'b1, 1'b0, 4'h8, 32'h0,        1'b1, 32'd103};

        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HREADY = 1'b1;
        bus.HWRITE = 1'b0; bus.HADDR = 32'h0; bus.HWDATA = 32'h0;
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
        check("reset_hrdata", bus.HRDATA, 32'd0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        for (int i = 0; i < 22; i++) begin
            xfer(vt[i].sel, vt[i].trans, vt[i].rdy, vt[i].wr, vt[i].addr, vt[i].wdata, r);
            if (vt[i].chk) check($sformatf("table_row%0d", i), r, vt[i].exp);
            check($sformatf("hreadyout_row%0d", i), {31'd0, bus.HREADYOUT}, 32'd1);
        end

        // DIV=3, 0x55: ten levels of four cycles each
        wr(4'h8, 32'd3);
        wr(4'h0, 32'h55);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (txd === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(posedge HCLK); #1;
        end
        check("div3_start_seen", {31'd0, found}, 32'd1);
        mism = 0;
        for (int k = 0; k < 40; k++) begin
            if (k / 4 == 0) expb = 1'b0;
            else if (k / 4 == 9) expb = 1'b1;
            else expb = ((8'h55 >> (k / 4 - 1)) & 8'h1) != 8'h0;
            if (txd !== expb) mism++;
            @(posedge HCLK); #1;
        end
        check("div3_waveform_mismatches", 32'(mism), 32'd0);
        wait_idle("div3_status_after", 50);

        // reset in the middle of bit 3 of a frame, with a byte still queued
        wr(4'h8, 32'd3);
        bb[0] = 8'hF0;
        bb[1] = 8'h0F;
        burst(2);
        check("rst_frame_started", {31'd0, tx_at[3]}, 32'd0);
        repeat (16) begin
            @(posedge HCLK); #1;
        end
        check("rst_bit3_level", {31'd0, txd}, 32'd0);
        HRESETn = 1'b0;
        #1;
        check("rst_async_txd", {31'd0, txd}, 32'd1);
        repeat (2) @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        rd(4'h4, r);
        check("rst_status", r, 32'h4);
        rd(4'h8, r);
        check("rst_div", r, 32'd103);
        highs = 0;
        for (int i = 0; i < 60; i++) begin
            if (txd === 1'b1) highs++;
            @(posedge HCLK); #1;
        end
        check("rst_line_quiet", 32'(highs), 32'd60);
        rd(4'h4, r);
        check("rst_status_quiet", r, 32'h4);

        // DIV=1, five back-to-back pushes
        wr(4'h8, 32'd1);
        mon_div = 1;
        mon_en  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bb[i] = 8'(i + 1);
            exp_q.push_back(bb[i]);
        end
        burst(5);
        check("b2b_idle_at_push", {31'd0, tx_at[2]}, 32'd1);
        check("b2b_start_after_push", {31'd0, tx_at[3]}, 32'd0);
        rd(4'h4, r);
        check("b2b_overflow", {31'd0, r[6]}, 32'd0);
        wait_idle("b2b_done", 200);
        repeat (2) @(posedge HCLK);
        #1;
        compare_rx("b2b_rx");

        // DIV=0, consecutive frames are exactly ten cycles apart
        wr(4'h8, 32'd0);
        mon_div = 0;
        bb[0] = 8'hA5; bb[1] = 8'h3C; bb[2] = 8'h0F;
        for (int i = 0; i < 3; i++) exp_q.push_back(bb[i]);
        burst(3);
        trace[0] = tx_at[3];
        trace[1] = tx_at[4];
        for (int t = 2; t < 40; t++) begin
            trace[t] = txd;
            @(posedge HCLK); #1;
        end
        for (int f = 0; f < 3; f++) begin
            check($sformatf("div0_start_frame%0d", f), {31'd0, trace[10*f]}, 32'd0);
            check($sformatf("div0_stop_frame%0d", f), {31'd0, trace[10*f+9]}, 32'd1);
        end
        check("div0_idle_after", {31'd0, trace[30]}, 32'd1);
        wait_idle("div0_done", 50);
        repeat (2) @(posedge HCLK);
        #1;
        compare_rx("div0_rx");

        // overflow with four bytes queued while the serializer is in DATA
        wr(4'h8, 32'd7);
        mon_div = 7;
        bb[0] = 8'h11; bb[1] = 8'h22; bb[2] = 8'h33; bb[3] = 8'h44; bb[4] = 8'h66;
        for (int i = 0; i < 5; i++) begin
            wr(4'h0, {24'h0, bb[i]});
            exp_q.push_back(bb[i]);
        end
        repeat (10) begin
            @(posedge HCLK); #1;
        end
        wr(4'h0, 32'hAA);
        rd(4'h4, r);
        check("ovf_status_set", r, 32'h63);
        wr(4'h4, 32'h40);
        rd(4'h4, r);
        check("ovf_status_clear", r, 32'h23);
        wait_idle("ovf_done", 600);
        repeat (2) @(posedge HCLK);
        #1;
        compare_rx("ovf_rx");

        // random byte streams at random divisors
        for (int round = 0; round < 3; round++) begin
            d = $urandom_range(0, 4);
            wr(4'h8, 32'(d));
            mon_div = d;
            n = $urandom_range(5, 10);
            for (int i = 0; i < n; i++) begin
                wait_not_full();
                b = 8'($urandom);
                wr(4'h0, {24'h0, b});
                exp_q.push_back(b);
                repeat ($urandom_range(0, 3)) begin
                    @(posedge HCLK); #1;
                end
            end
            wait_idle($sformatf("rand%0d_done", round), 1000);
            repeat (2) @(posedge HCLK);
            #1;
            compare_rx($sformatf("rand%0d_rx", round));
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
